// File: rtl/sipo_deser_pkg.sv
// Shared deserializer definitions: default word width, clog2 and the frame
// length (data bits, plus one even-parity bit when DESER_PARITY_EN is set).
package sipo_deser_pkg;

  localparam int DESER_WIDTH_DEF = 8;

  // Ceiling log2 usable in parameter expressions.
  function automatic int clog2(input int v);
    int r;
    int x;
    r = 0;
    x = v - 1;
    while (x > 0) begin
      r++;
      x = x >> 1;
    end
    return r;
  endfunction

  // Bits per frame on the serial side.
  function automatic int frame_len(input int w);
`ifdef DESER_PARITY_EN
    return w + 1;
`else
    return w;
`endif
  endfunction

endpackage

// File: rtl/sipo_deser_shift_in.sv
// shift_in: WIDTH-bit left shift register, LSB fed by din, with enable and
// synchronous clear (clear wins).
module shift_in #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             en,
  input  logic             din,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] q_q, q_d;

  // next shift value
  always_comb begin
    q_d = q_q;
    if (en) q_d = {q_q[WIDTH-2:0], din};
  end

  // state register, clear overrides shifting
  always_ff @(posedge clk) begin
    if (clr) q_q <= '0;
    else     q_q <= q_d;
  end

  assign q = q_q;

endmodule

// File: rtl/sipo_deser.sv
// sipo_deser: serial-in parallel-out deserializer with valid/ready on both
// sides and a double-buffered output word. Optional DESER_PARITY_EN adds a
// trailing even-parity bit per frame and the out_parity_err output.
module sipo_deser
  import sipo_deser_pkg::*;
#(
  parameter int WIDTH = DESER_WIDTH_DEF,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic             in_bit,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
`ifdef DESER_PARITY_EN
  ,
  output logic             out_parity_err
`endif
);

  localparam int               F    = frame_len(WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(F - 1);

  logic [WIDTH-1:0] shreg;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             last_bit, accept, take, done;

  assign last_bit = (cnt_q == LAST);
  // Only the closing bit of a second word has to wait for the consumer.
  assign in_ready = ~(out_valid_q & ~out_ready & last_bit);
  assign accept   = in_valid & in_ready;
  assign take     = out_valid_q & out_ready;
  assign done     = accept & last_bit;

  shift_in #(.WIDTH(WIDTH)) u_shreg (
    .clk (clk),
    .clr (reset),
    .en  (accept),
    .din (in_bit),
    .q   (shreg)
  );

  // bit counter and output buffer next state
  always_comb begin
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    if (accept) cnt_d = last_bit ? '0 : cnt_q + 1'b1;
    if (done) begin
      out_valid_d = 1'b1;
`ifdef DESER_PARITY_EN
      // closing bit is parity, data bits are already in shreg
      out_data_d  = shreg;
`else
      out_data_d  = {shreg[WIDTH-2:0], in_bit};
`endif
    end else if (take) begin
      out_valid_d = 1'b0;
    end
  end

  // counter and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

`ifdef DESER_PARITY_EN
  logic perr_q, perr_d;

  // parity error captured with the word, dropped with out_valid
  always_comb begin
    perr_d = perr_q;
    if (done)      perr_d = (^shreg) ^ in_bit;
    else if (take) perr_d = 1'b0;
  end

  // parity error register
  always_ff @(posedge clk) begin
    if (reset) perr_q <= 1'b0;
    else       perr_q <= perr_d;
  end

  assign out_parity_err = perr_q;
`endif

endmodule

// File: tb/tb_sipo_deser.sv
// Bench for sipo_deser: directed scenarios plus random traffic checked
// against a bit-queue reference model.
module tb_sipo_deser;
  import sipo_deser_pkg::*;

  localparam int W     = 8;
  localparam int F     = frame_len(W);
  localparam int CNT_W = clog2(F);

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid, in_bit, in_ready;
  logic         out_valid, out_ready;
  logic [W-1:0] out_data;
`ifdef DESER_PARITY_EN
  logic         out_parity_err;
`endif

  sipo_deser #(.WIDTH(W), .CNT_W(CNT_W)) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_bit   (in_bit),
    .in_ready (in_ready),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data)
`ifdef DESER_PARITY_EN
    ,
    .out_parity_err(out_parity_err)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // reference model: bits of the frame in progress, and the output buffer
  logic         bq[$];
  logic         m_vld;
  logic [W-1:0] m_word;
  logic         m_perr;

  task automatic model_reset();
    bq.delete();
    m_vld  = 1'b0;
    m_word = '0;
    m_perr = 1'b0;
  endtask

  // one clock: drive, check outputs against model, clock, advance model
  task automatic step(input logic v, input logic b, input logic r, output logic acc);
    logic exp_rdy, take;
    logic [W-1:0] w;
    logic p;
    in_valid = v; in_bit = b; out_ready = r;
    #1;
    exp_rdy = !(m_vld && !r && bq.size() == F - 1);
    chk("in_ready", {31'd0, in_ready}, {31'd0, exp_rdy});
    chk("out_valid", {31'd0, out_valid}, {31'd0, m_vld});
    chk("out_data", {24'd0, out_data}, {24'd0, m_word});
`ifdef DESER_PARITY_EN
    chk("perr", {31'd0, out_parity_err}, {31'd0, m_vld ? m_perr : 1'b0});
`endif
    @(posedge clk);
    acc  = v && exp_rdy;
    take = m_vld && r;
    if (acc) begin
      bq.push_back(b);
      if (bq.size() == F) begin
        w = '0; p = 1'b0;
        for (int i = 0; i < W; i++) w = {w[W-2:0], bq[i]};
        for (int i = 0; i < F; i++) p = p ^ bq[i];
        m_word = w;
        m_perr = (F > W) ? p : 1'b0;
        m_vld  = 1'b1;
        bq.delete();
      end else if (take) m_vld = 1'b0;
    end else if (take) m_vld = 1'b0;
    #1;
  endtask

  function automatic logic even_par(input logic [W-1:0] w);
    return ^w;
  endfunction

  // frame bits MSB first, parity bit appended when the feature is on
  task automatic frame_bits(input logic [W-1:0] w, input logic par, output logic [W:0] fb);
    fb = '0;
    for (int i = 0; i < W; i++) fb[i] = w[W-1-i];
    fb[W] = par;
  endtask

  task automatic send_bit(input logic b, input logic r);
    logic a;
    int tries;
    a = 1'b0; tries = 0;
    while (!a && tries < 8) begin
      step(1'b1, b, r, a);
      tries++;
    end
    if (!a) chk("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic send_word(input logic [W-1:0] w, input logic par, input logic r);
    logic [W:0] fb;
    frame_bits(w, par, fb);
    for (int i = 0; i < F; i++) send_bit(fb[i], r);
  endtask

  task automatic idle(input int n, input logic r);
    logic a;
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, r, a);
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    in_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic a;
    logic [W:0] fb;
    logic [W-1:0] rw;
    in_valid = 1'b0; in_bit = 1'b0; out_ready = 1'b0;
    model_reset();

    // reset then idle
    do_reset(2);
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_data", {24'd0, out_data}, 32'd0);
    chk("rst_ready", {31'd0, in_ready}, 32'd1);
    idle(3, 1'b1);

    // single word B2; valid appears the cycle after the last bit
    send_word(8'hB2, even_par(8'hB2), 1'b1);
    chk("single_vld", {31'd0, out_valid}, 32'd1);
    chk("single_data", {24'd0, out_data}, 32'hB2);
    idle(1, 1'b1);
    chk("single_drop", {31'd0, out_valid}, 32'd0);
    chk("single_keep", {24'd0, out_data}, 32'hB2);

    // backpressure: A5 held, 3C closing bit stalls until consumer ready
    send_word(8'hA5, even_par(8'hA5), 1'b0);
    frame_bits(8'h3C, even_par(8'h3C), fb);
    for (int i = 0; i < F - 1; i++) send_bit(fb[i], 1'b0);
    chk("bp_hold", {24'd0, out_data}, 32'hA5);
    step(1'b1, fb[F-1], 1'b0, a);
    chk("bp_stall1", {31'd0, a}, 32'd0);
    step(1'b1, fb[F-1], 1'b0, a);
    chk("bp_stall2", {31'd0, a}, 32'd0);
    step(1'b1, fb[F-1], 1'b1, a);
    chk("bp_accept", {31'd0, a}, 32'd1);
    chk("bp_vld", {31'd0, out_valid}, 32'd1);
    chk("bp_data", {24'd0, out_data}, 32'h3C);
    idle(2, 1'b1);

    // gapped input F0
    frame_bits(8'hF0, even_par(8'hF0), fb);
    for (int i = 0; i < F; i++) begin
      send_bit(fb[i], 1'b1);
      if (i == 1 || i == 4) idle(3, 1'b1);
    end
    chk("gap_data", {24'd0, out_data}, 32'hF0);
    idle(1, 1'b1);

    // reset mid-frame, with a pending unconsumed word as well
    send_word(8'h55, even_par(8'h55), 1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1, 1'b0);
    do_reset(1);
    chk("mid_rst_vld", {31'd0, out_valid}, 32'd0);
    chk("mid_rst_data", {24'd0, out_data}, 32'd0);
    send_word(8'h81, even_par(8'h81), 1'b1);
    chk("mid_rst_word", {24'd0, out_data}, 32'h81);
    idle(1, 1'b1);

`ifdef DESER_PARITY_EN
    send_word(8'h03, 1'b0, 1'b0);
    chk("par_ok_data", {24'd0, out_data}, 32'h03);
    chk("par_ok_err", {31'd0, out_parity_err}, 32'd0);
    idle(1, 1'b1);
    send_word(8'h03, 1'b1, 1'b0);
    chk("par_bad_data", {24'd0, out_data}, 32'h03);
    chk("par_bad_err", {31'd0, out_parity_err}, 32'd1);
    idle(1, 1'b1);
    chk("par_clr", {31'd0, out_parity_err}, 32'd0);
`endif

    // random traffic, occasional bad parity and rare resets
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 499) == 0) do_reset(1);
      else step($urandom_range(0, 3) != 0, 1'($urandom), $urandom_range(0, 4) < 3, a);
    end

    // random whole words with continuous ready
    for (int n = 0; n < 20; n++) begin
      rw = W'($urandom);
      send_word(rw, even_par(rw) ^ ($urandom_range(0, 3) == 0), 1'b1);
    end
    idle(2, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
